// File: rtl/uart_tx_scheduler_if.sv
// Handshake bundle between the CPU debug port, the heartbeat enable and the uart_tx instance.
// master = requester/transmitter side, slave = uart_tx_scheduler.
interface uart_tx_scheduler_if #(
  parameter int unsigned FIFO_DEPTH = 8
);
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  logic [7:0]    cpu_tx_byte;
  logic          cpu_tx_valid;
  logic          cpu_tx_ready;
  logic          hb_enable;
  logic          utx_dv;
  logic [7:0]    utx_byte;
  logic          utx_done;
  logic [CW-1:0] fifo_count;
  logic          overflow;
  logic          timeout_err;

  modport master (
    output cpu_tx_byte, cpu_tx_valid, hb_enable, utx_done,
    input  cpu_tx_ready, utx_dv, utx_byte, fifo_count, overflow, timeout_err
  );

  modport slave (
    input  cpu_tx_byte, cpu_tx_valid, hb_enable, utx_done,
    output cpu_tx_ready, utx_dv, utx_byte, fifo_count, overflow, timeout_err
  );
endinterface

// File: rtl/uart_tx_scheduler.sv
// Arbitrates the debug uart_tx between a CPU byte FIFO and a periodic heartbeat byte.
// Optional BUSY-state done timeout: define UART_TX_SCHED_TIMEOUT_EN.
module uart_tx_scheduler #(
  parameter int unsigned FIFO_DEPTH     = 8,
  parameter int unsigned HB_PERIOD      = 12000000,
  parameter logic [7:0]  HB_BYTE        = 8'h2E,
  parameter int unsigned TIMEOUT_CYCLES = 2048
) (
  input logic               CLK12MHZ,
  input logic               resetn,
  uart_tx_scheduler_if.slave bus
);
  localparam int unsigned AW  = $clog2(FIFO_DEPTH);
  localparam int unsigned CW  = AW + 1;
  localparam int unsigned HBW = (HB_PERIOD > 1) ? $clog2(HB_PERIOD) : 1;
  localparam logic [HBW-1:0] HB_LAST = HBW'(HB_PERIOD - 1);
  localparam logic [CW-1:0]  FULL    = CW'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("uart_tx_scheduler: FIFO_DEPTH must be a power of two >= 2");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("uart_tx_scheduler: TIMEOUT_CYCLES must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, START, BUSY, GAP} state_t;

  state_t          state, state_next;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count, count_next;
  logic            ready_q;
  logic            push, pop;

  logic [HBW-1:0]  hb_cnt;
  logic            hb_pending, hb_tick, hb_take;

  logic [7:0]      load_byte;
  logic            dv_q;
  logic [7:0]      byte_q;
  logic            overflow_q;
  logic            timeout_q;
  logic            timeout_hit;

  // ---------------------------------------------------------------- FIFO
  assign push       = bus.cpu_tx_valid & ready_q;
  assign count_next = count + CW'(push) - CW'(pop);

  always_ff @(posedge CLK12MHZ) begin
    if (push) mem[wr_ptr] <= bus.cpu_tx_byte;
  end

  // ready is a register tracking count_next so it never depends on this cycle's pop
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      ready_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_next;
      ready_q <= (count_next != FULL);
      if (bus.cpu_tx_valid && !ready_q) overflow_q <= 1'b1;
    end
  end

  // ----------------------------------------------------------- heartbeat
  assign hb_tick = bus.hb_enable && (hb_cnt == HB_LAST);

  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      hb_cnt     <= '0;
      hb_pending <= 1'b0;
    end else if (!bus.hb_enable) begin
      hb_cnt     <= '0;
      hb_pending <= 1'b0;
    end else begin
      hb_cnt <= hb_tick ? '0 : hb_cnt + HBW'(1);
      // a fresh tick on the same edge as a take re-arms the request
      if (hb_tick)      hb_pending <= 1'b1;
      else if (hb_take) hb_pending <= 1'b0;
    end
  end

  // ----------------------------------------------------- optional timeout
`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] BUSY_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] busy_cnt;

  assign timeout_hit = (state == BUSY) && !bus.utx_done && (busy_cnt == BUSY_LAST);

  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      busy_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      busy_cnt <= (state == BUSY) ? busy_cnt + TW'(1) : '0;
      if (timeout_hit) timeout_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign timeout_q   = 1'b0;
`endif

  // ----------------------------------------------------------------- FSM
  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (count != '0 || hb_pending) state_next = START;
      START:   state_next = BUSY;
      BUSY:    if (bus.utx_done || timeout_hit) state_next = GAP;
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    pop       = 1'b0;
    hb_take   = 1'b0;
    load_byte = byte_q;
    if (state == IDLE) begin
      if (count != '0) begin
        pop       = 1'b1;
        load_byte = mem[rd_ptr];
      end else if (hb_pending) begin
        hb_take   = 1'b1;
        load_byte = HB_BYTE;
      end
    end
  end

  always_ff @(posedge CLK12MHZ or negedge resetn) begin
    if (!resetn) begin
      dv_q   <= 1'b0;
      byte_q <= 8'h00;
    end else begin
      dv_q   <= (state_next == START);
      byte_q <= load_byte;
    end
  end

  assign bus.cpu_tx_ready = ready_q;
  assign bus.utx_dv       = dv_q;
  assign bus.utx_byte     = byte_q;
  assign bus.fifo_count   = count;
  assign bus.overflow     = overflow_q;
  assign bus.timeout_err  = timeout_q;
endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench: directed pushes queue expected bytes; a negedge monitor checks every utx_dv strobe.
module tb_uart_tx_scheduler;
  localparam int unsigned DEPTH = 8;

  logic clk = 1'b0;
  logic resetn;

  uart_tx_scheduler_if #(.FIFO_DEPTH(DEPTH)) bus ();

  uart_tx_scheduler #(
    .FIFO_DEPTH    (DEPTH),
    .HB_PERIOD     (16),
    .HB_BYTE       (8'h2E),
    .TIMEOUT_CYCLES(32)
  ) dut (
    .CLK12MHZ(clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];
  int cyc = 0;
  int credits_given = 0;
  int credits_used  = 0;
  bit auto_done = 1'b0;
  bit resp_busy = 1'b0;
  int dv_seen = 0;
  int last_dv_cyc = 0;
  int dv_gap = 0;
  bit in_flight = 1'b0;
  bit prev_dv = 1'b0;
  logic [7:0] held = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: pops the scoreboard on every strobe and watches strobe width / byte hold
  always @(negedge clk) begin
    if (!resetn) begin
      in_flight = 1'b0;
      prev_dv   = 1'b0;
    end else begin
      if (bus.utx_dv) begin
        chk("dv_width", int'(prev_dv), 0);
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_strobe actual=0x%0h required=none", bus.utx_byte);
        end else begin
          logic [7:0] e;
          e = exp_q.pop_front();
          if (bus.utx_byte !== e) begin
            errors++;
            $display("FAIL strobe_byte actual=0x%0h required=0x%0h", bus.utx_byte, e);
          end
        end
        held        = bus.utx_byte;
        in_flight   = 1'b1;
        dv_gap      = cyc - last_dv_cyc;
        last_dv_cyc = cyc;
        dv_seen++;
      end else if (in_flight) begin
        chk("byte_hold", int'(bus.utx_byte), int'(held));
        if (bus.utx_done) in_flight = 1'b0;
      end
      prev_dv = bus.utx_dv;
    end
  end

  // Responder: plays uart_tx, returning done two cycles into BUSY when allowed
  initial begin
    int dly;
    dly = 0;
    bus.utx_done = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      bus.utx_done = 1'b0;
      if (!resetn) resp_busy = 1'b0;
      else if (bus.utx_dv) begin
        resp_busy = 1'b1;
        dly = 0;
      end else if (resp_busy) begin
        dly++;
        if (dly >= 2 && (auto_done || credits_used < credits_given)) begin
          bus.utx_done = 1'b1;
          resp_busy = 1'b0;
          if (!auto_done) credits_used++;
        end
      end
    end
  end

  task automatic push(input logic [7:0] b);
    @(negedge clk);
    bus.cpu_tx_valid = 1'b1;
    bus.cpu_tx_byte  = b;
    @(posedge clk);
    #1;
    bus.cpu_tx_valid = 1'b0;
  endtask

  task automatic push_exp(input logic [7:0] b);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (bus.cpu_tx_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL push_wait actual=ready_low required=ready_high");
    end else begin
      exp_q.push_back(b);
      bus.cpu_tx_valid = 1'b1;
      bus.cpu_tx_byte  = b;
      @(posedge clk);
      #1;
      bus.cpu_tx_valid = 1'b0;
    end
  endtask

  task automatic drain(input string name, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !resp_busy && !in_flight) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d_outstanding required=0", name, exp_q.size());
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_dv(input string name, input int target, input int limit);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (dv_seen >= target) begin
        ok = 1'b1;
        break;
      end
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s actual=%0d_strobes required=%0d", name, dv_seen, target);
    end
  endtask

  initial begin
    int base;
    resetn           = 1'b0;
    bus.cpu_tx_valid = 1'b0;
    bus.cpu_tx_byte  = 8'h00;
    bus.hb_enable    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ready",    int'(bus.cpu_tx_ready), 1);
    chk("rst_count",    int'(bus.fifo_count),   0);
    chk("rst_dv",       int'(bus.utx_dv),       0);
    chk("rst_byte",     int'(bus.utx_byte),     0);
    chk("rst_overflow", int'(bus.overflow),     0);
    chk("rst_timeout",  int'(bus.timeout_err),  0);
    resetn = 1'b1;

    // Single byte: latency and hold until done
    exp_q.push_back(8'h41);
    push(8'h41);
    @(negedge clk);
    chk("t1_count_after_push", int'(bus.fifo_count), 1);
    chk("t1_dv_early",         int'(bus.utx_dv),     0);
    @(negedge clk);
    chk("t1_dv_latency",       int'(bus.utx_dv),     1);
    chk("t1_count_after_pop",  int'(bus.fifo_count), 0);
    repeat (5) @(negedge clk);
    chk("t1_byte_held",        int'(bus.utx_byte),   8'h41);
    credits_given++;
    drain("t1_drain", 50);
    chk("t1_count_final",      int'(bus.fifo_count), 0);

    // Fill to full with done withheld, then overflow
    for (int i = 0; i < 9; i++) push_exp(8'(i));
    @(negedge clk);
    chk("t2_count_full", int'(bus.fifo_count),   8);
    chk("t2_ready_full", int'(bus.cpu_tx_ready), 0);
    push(8'hFF);
    @(negedge clk);
    chk("t2_overflow",       int'(bus.overflow),   1);
    chk("t2_count_after_ff", int'(bus.fifo_count), 8);
    credits_given += 9;
    drain("t2_drain", 400);
    chk("t2_count_final",    int'(bus.fifo_count), 0);
    chk("t2_overflow_stick", int'(bus.overflow),   1);

    // Heartbeat cadence, then FIFO priority over a pending heartbeat
    auto_done = 1'b1;
    base = dv_seen;
    repeat (3) exp_q.push_back(8'h2E);
    bus.hb_enable = 1'b1;
    wait_dv("t3_hb_strobes", base + 3, 200);
    auto_done = 1'b0;
    chk("t3_hb_period", dv_gap, 16);
    repeat (18) @(negedge clk);
    exp_q.push_back(8'h55);
    exp_q.push_back(8'h2E);
    push(8'h55);
    credits_given++;
    wait_dv("t3_cpu_first", base + 4, 100);
    credits_given++;
    wait_dv("t3_hb_after_cpu", base + 5, 100);
    bus.hb_enable = 1'b0;
    credits_given++;
    drain("t3_drain", 100);
    base = dv_seen;
    repeat (40) @(negedge clk);
    chk("t3_hb_disabled", dv_seen - base, 0);

    // Push and pop on the same edge at count 3, then wrap the pointers
    for (int i = 0; i < 4; i++) push_exp(8'h60 + 8'(i));
    repeat (5) @(negedge clk);
    chk("t4_count_pre", int'(bus.fifo_count), 3);
    credits_given++;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("t4_count_before_edge", int'(bus.fifo_count), 3);
    exp_q.push_back(8'h64);
    bus.cpu_tx_valid = 1'b1;
    bus.cpu_tx_byte  = 8'h64;
    @(posedge clk);
    #1;
    bus.cpu_tx_valid = 1'b0;
    @(negedge clk);
    chk("t4_pop_happened",    int'(bus.utx_dv),     1);
    chk("t4_count_unchanged", int'(bus.fifo_count), 3);
    auto_done = 1'b1;
    for (int i = 5; i < 20; i++) push_exp(8'h60 + 8'(i));
    drain("t4_drain", 800);
    chk("t4_count_final", int'(bus.fifo_count), 0);

    // Asynchronous reset while BUSY with 4 bytes queued
    auto_done = 1'b0;
    push_exp(8'h80);
    for (int i = 1; i < 5; i++) push(8'h80 + 8'(i));
    repeat (4) @(negedge clk);
    chk("t5_count_pre",    int'(bus.fifo_count), 4);
    chk("t5_overflow_pre", int'(bus.overflow),   1);
    #2;
    resetn = 1'b0;
    #1;
    chk("t5_async_dv",       int'(bus.utx_dv),       0);
    chk("t5_async_count",    int'(bus.fifo_count),   0);
    chk("t5_async_overflow", int'(bus.overflow),     0);
    chk("t5_async_ready",    int'(bus.cpu_tx_ready), 1);
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    auto_done = 1'b1;
    base = dv_seen;
    repeat (60) @(negedge clk);
    chk("t5_no_resend", dv_seen - base, 0);

    // Done-wait limit
    auto_done = 1'b0;
    base = dv_seen;
`ifdef UART_TX_SCHED_TIMEOUT_EN
    push_exp(8'hC0);
    push_exp(8'hC1);
    wait_dv("t6_next_after_timeout", base + 2, 200);
    chk("t6_timeout_gap", dv_gap, 35);
    chk("t6_timeout_err", int'(bus.timeout_err), 1);
    credits_given++;
    drain("t6_drain", 100);
`else
    push_exp(8'hC0);
    push_exp(8'hC1);
    wait_dv("t6_first", base + 1, 50);
    repeat (100) @(negedge clk);
    chk("t6_busy_waits",  dv_seen - base, 1);
    chk("t6_timeout_err", int'(bus.timeout_err), 0);
    credits_given += 2;
    drain("t6_drain", 100);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "bench time limit");
  end
endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
- Sequences the debug UART transmitter (uart_tx, CLKS_PER_BIT=104) between two requesters: the CPU debug byte port and an internal periodic heartbeat.
- Buffers CPU bytes in a small FIFO.
- Issues one-cycle data-valid strobes to uart_tx and waits for its done pulse before issuing the next byte.
- Sits in top between riscv_multi's debug outputs and the uart_tx instance.

Parameters:
- FIFO_DEPTH, 8, CPU byte FIFO entries; power of two, at least 2.
- HB_PERIOD, 12000000, heartbeat interval in CLK12MHZ cycles (1 s).
- HB_BYTE, 8'h2E, byte sent on each heartbeat ('.').
- TIMEOUT_CYCLES, 2048, done-wait limit; used only with the optional feature.

Ports:
- CLK12MHZ  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- cpu_tx_byte  in  8  CPU debug byte.
- cpu_tx_valid  in  1  push strobe, sampled each edge.
- cpu_tx_ready  out  1  FIFO not full.
- hb_enable  in  1  heartbeat enable.
- utx_dv  out  1  to uart_tx i_Tx_DV.
- utx_byte  out  8  to uart_tx i_Tx_Byte.
- utx_done  in  1  from uart_tx o_Tx_Done (one-cycle pulse).
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky: a CPU byte was dropped.
- timeout_err  out  1  sticky: done-wait expired. Tied to 0 when the optional feature is compiled out.

Behaviour:
- Reset (resetn=0, asynchronous):
  - FIFO empties; fifo_count=0; cpu_tx_ready=1.
  - utx_dv=0, utx_byte=8'h00, overflow=0, timeout_err=0.
  - Heartbeat counter=0, hb_pending=0, FSM=IDLE.
  - A byte in flight when reset asserts is abandoned, not resent.
- All outputs are registered.
- Push:
  - Accepted when cpu_tx_valid=1 and cpu_tx_ready=1.
  - cpu_tx_ready is derived from the registered count. A push while full is dropped and sets overflow, even if a pop occurs on the same edge.
  - A push and a pop on the same edge leave fifo_count unchanged.
- FIFO read/write pointers wrap modulo FIFO_DEPTH. fifo_count saturates at FIFO_DEPTH and never underflows.
- Heartbeat:
  - While hb_enable=1, the counter counts 0..HB_PERIOD-1.
  - At terminal count it wraps to 0 and sets hb_pending.
  - A tick while hb_pending is already set is lost; there is no accumulation.
  - hb_enable=0 holds the counter at 0 and clears hb_pending.
- FSM:
  - IDLE:
    - If fifo_count>0, pop the FIFO head into utx_byte and go to START.
    - Else if hb_pending, load HB_BYTE, clear hb_pending, go to START.
    - The FIFO always has priority over the heartbeat.
  - START: utx_dv=1 for exactly this one cycle; go to BUSY.
  - BUSY:
    - utx_byte is held stable.
    - On utx_done=1, go to GAP.
    - A utx_done pulse seen in any state other than BUSY is ignored.
  - GAP: one idle cycle, then IDLE. This guarantees uart_tx has returned to idle before the next strobe.
- Latency: a push sampled on edge E into an empty FIFO with the FSM in IDLE gives utx_dv=1 in the cycle after edge E+1.
- Back-to-back throughput: one byte per uart_tx frame plus 3 cycles (START, done edge, GAP).

Optional Feature:
- Macro: UART_TX_SCHED_TIMEOUT_EN.
- Defined:
  - A BUSY-state cycle counter starts at 0 on BUSY entry.
  - If it reaches TIMEOUT_CYCLES-1 without utx_done, the FSM goes to GAP and sets timeout_err (sticky until reset).
  - The byte is not retransmitted.
- Undefined: no counter; BUSY waits indefinitely; timeout_err is constant 0.

Test Plan:
- Reset release, push 8'h41 once with hb_enable=0 → utx_dv pulse 1 cycle, utx_byte=8'h41 held until the bench pulses utx_done; fifo_count returns 0.
- Push 9 bytes 8'h00..8'h08 back-to-back with utx_done withheld (1 byte popped) → 8'h00 in flight, 8 queued, cpu_tx_ready=0 on the 10th push attempt. A further push of 8'hFF sets overflow=1. Then pulse utx_done 8 times → bytes 8'h01..8'h08 emitted in order; 8'hFF never appears.
- hb_enable=1 with HB_PERIOD overridden to 16, FIFO empty → utx_byte=8'h2E strobed every ~16 cycles (done returned promptly). Push 8'h55 while a heartbeat is pending → 8'h55 sent first, then 8'h2E.
- Simultaneous push and pop with fifo_count=3 → fifo_count stays 3; FIFO order preserved across pointer wrap (push 20 bytes total, all received in order).
- Assert resetn=0 in BUSY with 4 bytes queued → utx_dv=0, fifo_count=0, overflow=0 immediately (asynchronous); no bytes emitted after release.
- With UART_TX_SCHED_TIMEOUT_EN and TIMEOUT_CYCLES=32, withhold utx_done → FSM returns to IDLE after 32 BUSY cycles, timeout_err=1, next queued byte is strobed.
